// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int PISO_DEF_WIDTH = 4;

endpackage

// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter: one word bit per cycle, registered outputs,
// zero-bubble reload on the last-bit cycle.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    piso_state_t      state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             sout_nxt, last_nxt;
    logic             accept;

    // Ready also on the last-bit cycle so a waiting word follows without a gap.
    assign load_ready = !rst && ((state == IDLE) || last);
    assign accept     = load_valid && load_ready;
    assign busy       = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        sout_nxt  = 1'b0;
        last_nxt  = 1'b0;
        if (accept) begin
            // First bit goes straight to sout; the register keeps the remainder.
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            if (MSB_FIRST) begin
                sout_nxt  = d[WIDTH-1];
                shreg_nxt = d << 1;
            end else begin
                sout_nxt  = d[0];
                shreg_nxt = d >> 1;
            end
        end else if (state == SHIFT) begin
            if (last) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                shreg_nxt = '0;
            end else begin
                cnt_nxt  = cnt + CW'(1);
                last_nxt = (cnt_nxt == CNT_MAX);
                if (MSB_FIRST) begin
                    sout_nxt  = shreg[WIDTH-1];
                    shreg_nxt = shreg << 1;
                end else begin
                    sout_nxt  = shreg[0];
                    shreg_nxt = shreg >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            last       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            sout       <= sout_nxt;
            sout_valid <= (state_nxt == SHIFT);
            last       <= last_nxt;
        end
    end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 shifts bit 0 first, 1 shifts bit WIDTH-1 first.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 d  input  WIDTH  parallel word to serialise; sampled only on an accept cycle.
REQ-006 load_valid  input  1  d holds a word to transmit.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial data bit, registered.
REQ-009 sout_valid  output  1  sout carries a word bit this cycle, registered.
REQ-010 last  output  1  current sout bit is the final bit of the word, registered.
REQ-011 busy  output  1  a word is in flight (state SHIFT).

Function
REQ-012 The block SHALL have exactly two states: IDLE and SHIFT.
REQ-013 Accept SHALL occur on any cycle where load_valid and load_ready are both 1; d is then captured into a WIDTH-bit shift register.
REQ-014 load_ready SHALL be 1 in IDLE and in the SHIFT cycle where last=1; it SHALL be 0 otherwise and during reset.
REQ-015 Latency: a word accepted at edge N SHALL present its first bit on sout, with sout_valid=1, from edge N+1.
REQ-016 One bit per cycle: bits SHALL appear on WIDTH consecutive cycles with no gaps, in the order selected by MSB_FIRST.
REQ-017 A bit counter, 0..WIDTH-1, SHALL advance once per SHIFT cycle; last=1 exactly when the counter equals WIDTH-1.
REQ-018 IDLE->SHIFT SHALL occur on accept.
REQ-019 SHIFT->IDLE SHALL occur on the last-bit cycle when no accept occurs.
REQ-020 Back-to-back: an accept on the last-bit cycle SHALL keep the state in SHIFT, reload the shift register, and clear the counter, so the new word's first bit follows with zero idle cycles.
REQ-021 load_valid asserted while load_ready=0 SHALL be ignored; d changes during SHIFT SHALL not affect the word in flight.
REQ-022 When sout_valid=0, sout and last SHALL be driven 0.
REQ-023 busy SHALL equal (state==SHIFT).

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counter=0, shift register=0, sout=0, sout_valid=0, last=0, busy=0; load_ready=1 from the first cycle after rst deasserts.
REQ-025 Reset mid-word SHALL discard the remaining bits; no further bits of that word SHALL be emitted.
REQ-026 rst SHALL take priority over a simultaneous accept.

Structure
REQ-027 A shared package piso_pkg SHALL hold the state enumeration (IDLE, SHIFT) and the default-width constant.
REQ-028 The implementation SHALL be a single module with no sub-module; the counter width SHALL be clog2(WIDTH).

Verification
REQ-029 WIDTH=4, MSB_FIRST=0, d=4'b0001 accepted at edge N -> sout=1,0,0,0 on edges N+1..N+4, last=1 at N+4 only, then busy=0.
REQ-030 Back-to-back: 4'b0010, then 4'b0100 held valid -> second accept at the last-bit cycle, stream 0,1,0,0,0,0,1,0 continuous, sout_valid never drops.
REQ-031 Accept 4'b1111, assert rst on the second bit cycle -> next edge sout_valid=0, busy=0, sout=0, and no further 1s appear.
REQ-032 Accept 4'b1000, then drive d=4'b0111 with load_valid=1 during SHIFT -> output 0,0,0,1 unchanged; 4'b0111 accepted only at the last-bit cycle.
REQ-033 MSB_FIRST=1, d=4'b1000 -> sout=1,0,0,0; WIDTH=8, d=8'hA5, MSB_FIRST=0 -> 1,0,1,0,0,1,0,1.
REQ-034 Random d over 1000 words with random load_valid gaps -> scoreboard reassembles every word exactly, and the cycle count equals WIDTH per word plus idle cycles.
